mem_access_unit: RTL and testbench

Memory-stage consumer of the EX/MEM pipeline register in the five-stage MIPS pipeline. It resolves branches and jumps from the EX/MEM flags, runs loads and stores against a data memory through a req/ack handshake, stalls the pipeline while an access is outstanding, and registers the write-back fields presented to MEM/WB.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mem_align.sv | 50 +++++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS memory stage: branch conditions,
// access widths, memory-stage FSM states and the data-memory command payload.
package mips_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_LT     = 3'd3;
  localparam logic [2:0] COND_GE     = 3'd4;
  localparam logic [2:0] COND_LE     = 3'd5;
  localparam logic [2:0] COND_GT     = 3'd6;
  localparam logic [2:0] COND_ALWAYS = 3'd7;

  localparam logic [1:0] LT_WORD = 2'b00;
  localparam logic [1:0] LT_SB   = 2'b01;
  localparam logic [1:0] LT_UB   = 2'b10;
  localparam logic [1:0] LT_SH   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_cmd_t;

  // Branch condition evaluation from the EX flags.
  function automatic logic cond_met(input logic [2:0] cond, input logic zero,
                                    input logic less);
    logic met;
    case (cond)
      COND_NEVER:  met = 1'b0;
      COND_Z:      met = zero;
      COND_NZ:     met = ~zero;
      COND_LT:     met = less;
      COND_GE:     met = ~less;
      COND_LE:     met = less | zero;
      COND_GT:     met = ~less & ~zero;
      COND_ALWAYS: met = 1'b1;
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction plus extension for loads.
module mem_align
  import mips_pkg::*;
(
  input  logic [1:0]  load_type,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] load_c,
  output logic        misaligned_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel     = rdata[{lane, 3'b000} +: 8];
  assign half_sel     = lane[1] ? rdata[31:16] : rdata[15:0];
  assign misaligned_c = (load_type == LT_SH) & lane[0];

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    load_c  = rdata;
    case (load_type)
      LT_WORD: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
        load_c  = rdata;
      end
      LT_SB: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{store_data[7:0]}};
        load_c  = {{24{byte_sel[7]}}, byte_sel};
      end
      LT_UB: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{store_data[7:0]}};
        load_c  = {24'd0, byte_sel};
      end
      default: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
        load_c  = {{16{half_sel[15]}}, half_sel};
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory stage: branch/jump redirect, req/ack data-memory access FSM with
// timeout, pipeline stall, and registered MEM/WB write-back and exceptions.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] PC_Branch_in,
  input  logic [31:0] PC_Jump_in,
  input  logic [31:0] ALUShift_out_in,
  input  logic [31:0] StoreData_in,
  input  logic        Jump_in,
  input  logic        Less_in,
  input  logic        Zero_in,
  input  logic        Overflow_in,
  input  logic [2:0]  Condition_in,
  input  logic [1:0]  LoadType_in,
  input  logic [1:0]  LoadByte_in,
  input  logic        RegWr_in,
  input  logic        MemWr_in,
  input  logic        MemtoReg_in,
  input  logic [4:0]  Rd_in,
  output logic        Redirect,
  output logic [31:0] Redirect_PC,
  output logic        Stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] WB_Data,
  output logic [4:0]  WB_Rd,
  output logic        WB_RegWr,
  output logic        Exc_Ovf,
  output logic        Exc_Bus
);

  mau_state_t        state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt, count_inc;
  dmem_cmd_t         cmd, cmd_nxt;
  logic              req_nxt;
  logic [1:0]        lt_q, lt_nxt, lane_q, lane_nxt;
  logic [4:0]        rd_q, rd_nxt;
  logic              ldwr_q, ldwr_nxt;
  logic [31:0]       wb_data_nxt;
  logic [4:0]        wb_rd_nxt;
  logic              wb_regwr_nxt, ovf_nxt, bus_nxt;

  logic              mem_op;
  logic [1:0]        sel_type, sel_lane;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, load_c;
  logic              misaligned_c;

  assign Redirect    = Jump_in | cond_met(Condition_in, Zero_in, Less_in);
  assign Redirect_PC = Jump_in ? PC_Jump_in : PC_Branch_in;

  assign mem_op    = MemtoReg_in | MemWr_in;
  assign count_inc = (count == '1) ? count : count + CNT_W'(1);

  // New ops are steered from the inputs; the in-flight load uses its latched lane.
  assign sel_type = (state == IDLE) ? LoadType_in : lt_q;
  assign sel_lane = (state == IDLE) ? LoadByte_in : lane_q;

  mem_align u_align (
    .load_type    (sel_type),
    .lane         (sel_lane),
    .store_data   (StoreData_in),
    .rdata        (dmem_rdata),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .load_c       (load_c),
    .misaligned_c (misaligned_c)
  );

  assign dmem_we    = cmd.we;
  assign dmem_addr  = cmd.addr;
  assign dmem_wdata = cmd.wdata;
  assign dmem_be    = cmd.be;

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    cmd_nxt      = cmd;
    req_nxt      = dmem_req;
    lt_nxt       = lt_q;
    lane_nxt     = lane_q;
    rd_nxt       = rd_q;
    ldwr_nxt     = ldwr_q;
    wb_data_nxt  = WB_Data;
    wb_rd_nxt    = WB_Rd;
    wb_regwr_nxt = 1'b0;
    ovf_nxt      = 1'b0;
    bus_nxt      = 1'b0;
    Stall        = 1'b0;
    unique case (state)
      IDLE: begin
        if (Overflow_in) begin
          ovf_nxt = 1'b1;
        end else if (mem_op) begin
          if (misaligned_c) begin
            bus_nxt = 1'b1;
          end else begin
            Stall     = 1'b1;
            state_nxt = ACCESS;
            count_nxt = '0;
            req_nxt   = 1'b1;
            cmd_nxt   = '{we: MemWr_in, addr: {ALUShift_out_in[31:2], 2'b00},
                          wdata: wdata_c, be: be_c};
            lt_nxt    = LoadType_in;
            lane_nxt  = LoadByte_in;
            rd_nxt    = Rd_in;
            ldwr_nxt  = RegWr_in & ~MemWr_in;
          end
        end else begin
          wb_data_nxt  = ALUShift_out_in;
          wb_rd_nxt    = Rd_in;
          wb_regwr_nxt = RegWr_in;
        end
      end
      ACCESS: begin
        Stall     = 1'b1;
        count_nxt = count_inc;
        if (dmem_ack) begin
          state_nxt    = DONE;
          req_nxt      = 1'b0;
          wb_data_nxt  = load_c;
          wb_rd_nxt    = rd_q;
          wb_regwr_nxt = ldwr_q;
        end else if (count_inc == CNT_W'(TIMEOUT)) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          bus_nxt   = 1'b1;
        end
      end
      DONE: begin
        // Held EX/MEM op is retired here rather than re-issued.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      cmd      <= '0;
      dmem_req <= 1'b0;
      lt_q     <= '0;
      lane_q   <= '0;
      rd_q     <= '0;
      ldwr_q   <= 1'b0;
      WB_Data  <= '0;
      WB_Rd    <= '0;
      WB_RegWr <= 1'b0;
      Exc_Ovf  <= 1'b0;
      Exc_Bus  <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      cmd      <= cmd_nxt;
      dmem_req <= req_nxt;
      lt_q     <= lt_nxt;
      lane_q   <= lane_nxt;
      rd_q     <= rd_nxt;
      ldwr_q   <= ldwr_nxt;
      WB_Data  <= wb_data_nxt;
      WB_Rd    <= wb_rd_nxt;
      WB_RegWr <= wb_regwr_nxt;
      Exc_Ovf  <= ovf_nxt;
      Exc_Bus  <= bus_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: redirect/write-back vector table plus
// hand-written load, store, timeout, overflow, misalignment and reset sequences.
module tb_mem_access_unit;
  import mips_pkg::*;

  logic        clk = 1'b1;
  logic        Reset;
  logic [31:0] PC_Branch_in, PC_Jump_in, ALUShift_out_in, StoreData_in;
  logic        Jump_in, Less_in, Zero_in, Overflow_in;
  logic [2:0]  Condition_in;
  logic [1:0]  LoadType_in, LoadByte_in;
  logic        RegWr_in, MemWr_in, MemtoReg_in;
  logic [4:0]  Rd_in;
  logic        Redirect, Stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] Redirect_PC, dmem_addr, dmem_wdata, dmem_rdata, WB_Data;
  logic [3:0]  dmem_be;
  logic [4:0]  WB_Rd;
  logic        WB_RegWr, Exc_Ovf, Exc_Bus;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .Reset(Reset),
    .PC_Branch_in(PC_Branch_in), .PC_Jump_in(PC_Jump_in),
    .ALUShift_out_in(ALUShift_out_in), .StoreData_in(StoreData_in),
    .Jump_in(Jump_in), .Less_in(Less_in), .Zero_in(Zero_in), .Overflow_in(Overflow_in),
    .Condition_in(Condition_in), .LoadType_in(LoadType_in), .LoadByte_in(LoadByte_in),
    .RegWr_in(RegWr_in), .MemWr_in(MemWr_in), .MemtoReg_in(MemtoReg_in), .Rd_in(Rd_in),
    .Redirect(Redirect), .Redirect_PC(Redirect_PC), .Stall(Stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .WB_Data(WB_Data), .WB_Rd(WB_Rd), .WB_RegWr(WB_RegWr),
    .Exc_Ovf(Exc_Ovf), .Exc_Bus(Exc_Bus)
  );

  typedef struct {
    logic [2:0]  cond;
    logic        zero, less, jump, ovf, regwr;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        exp_redirect;
    logic [31:0] exp_pc;
    logic        exp_regwr, exp_ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the active (falling) edge; outputs are sampled there too.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_in();
    PC_Branch_in = 32'h40;  PC_Jump_in = 32'h100;
    ALUShift_out_in = '0;   StoreData_in = '0;
    Jump_in = 1'b0; Less_in = 1'b0; Zero_in = 1'b0; Overflow_in = 1'b0;
    Condition_in = 3'd0; LoadType_in = 2'd0; LoadByte_in = 2'd0;
    RegWr_in = 1'b0; MemWr_in = 1'b0; MemtoReg_in = 1'b0; Rd_in = 5'd0;
    dmem_rdata = '0; dmem_ack = 1'b0;
  endtask

  task automatic mem_load(input string name, input logic [1:0] lt, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [31:0] exp);
    clear_in();
    MemtoReg_in = 1'b1; RegWr_in = 1'b1; LoadType_in = lt;
    LoadByte_in = addr[1:0]; ALUShift_out_in = addr; Rd_in = rd;
    #1;
    chk($sformatf("%s stall_idle", name), 32'(Stall), 32'd1);
    chk($sformatf("%s req_idle", name), 32'(dmem_req), 32'd0);
    tick();
    chk($sformatf("%s stall_access", name), 32'(Stall), 32'd1);
    chk($sformatf("%s req_access", name), 32'(dmem_req), 32'd1);
    chk($sformatf("%s addr", name), dmem_addr, {addr[31:2], 2'b00});
    chk($sformatf("%s we", name), 32'(dmem_we), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0;
    chk($sformatf("%s stall_done", name), 32'(Stall), 32'd0);
    chk($sformatf("%s req_done", name), 32'(dmem_req), 32'd0);
    chk($sformatf("%s wb_regwr", name), 32'(WB_RegWr), 32'd1);
    chk($sformatf("%s wb_data", name), WB_Data, exp);
    chk($sformatf("%s wb_rd", name), 32'(WB_Rd), 32'(rd));
    clear_in();
    tick();
    chk($sformatf("%s wb_regwr_after", name), 32'(WB_RegWr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            cond  z     l     j     ovf   rw    alu       rd     R     pc        wr    ovf
    vecs[0]  = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 5'd3,  1'b1, 32'h40,  1'b1, 1'b0};
    vecs[1]  = '{3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22, 5'd4,  1'b1, 32'h100, 1'b1, 1'b0};
    vecs[2]  = '{3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h33, 5'd5,  1'b0, 32'h40,  1'b1, 1'b0};
    vecs[3]  = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 5'd6,  1'b0, 32'h40,  1'b0, 1'b0};
    vecs[4]  = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 5'd7,  1'b1, 32'h40,  1'b1, 1'b0};
    vecs[5]  = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h66, 5'd8,  1'b1, 32'h40,  1'b1, 1'b0};
    vecs[6]  = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 5'd9,  1'b0, 32'h40,  1'b1, 1'b0};
    vecs[7]  = '{3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h88, 5'd10, 1'b1, 32'h40,  1'b1, 1'b0};
    vecs[8]  = '{3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 5'd11, 1'b1, 32'h40,  1'b1, 1'b0};
    vecs[9]  = '{3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA, 5'd12, 1'b0, 32'h40,  1'b1, 1'b0};
    vecs[10] = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBB, 5'd13, 1'b1, 32'h40,  1'b1, 1'b0};
    vecs[11] = '{3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCC, 5'd14, 1'b1, 32'h100, 1'b1, 1'b0};
    vecs[12] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDD, 5'd15, 1'b0, 32'h40,  1'b0, 1'b1};

    clear_in();
    Reset = 1'b0;
    tick();
    tick();
    chk("reset wb_data", WB_Data, 32'd0);
    chk("reset wb_rd", 32'(WB_Rd), 32'd0);
    chk("reset wb_regwr", 32'(WB_RegWr), 32'd0);
    chk("reset req", 32'(dmem_req), 32'd0);
    chk("reset exc_ovf", 32'(Exc_Ovf), 32'd0);
    chk("reset exc_bus", 32'(Exc_Bus), 32'd0);
    chk("reset stall", 32'(Stall), 32'd0);
    Reset = 1'b1;
    tick();

    // Redirect resolution and single-edge write-back for non-memory ops.
    for (int i = 0; i < 13; i++) begin
      clear_in();
      Condition_in = vecs[i].cond; Zero_in = vecs[i].zero; Less_in = vecs[i].less;
      Jump_in = vecs[i].jump; Overflow_in = vecs[i].ovf; RegWr_in = vecs[i].regwr;
      ALUShift_out_in = vecs[i].alu; Rd_in = vecs[i].rd;
      #1;
      chk($sformatf("vec%0d redirect", i), 32'(Redirect), 32'(vecs[i].exp_redirect));
      chk($sformatf("vec%0d redirect_pc", i), Redirect_PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d stall", i), 32'(Stall), 32'd0);
      tick();
      chk($sformatf("vec%0d wb_regwr", i), 32'(WB_RegWr), 32'(vecs[i].exp_regwr));
      chk($sformatf("vec%0d exc_ovf", i), 32'(Exc_Ovf), 32'(vecs[i].exp_ovf));
      if (vecs[i].exp_regwr) begin
        chk($sformatf("vec%0d wb_data", i), WB_Data, vecs[i].alu);
        chk($sformatf("vec%0d wb_rd", i), 32'(WB_Rd), 32'(vecs[i].rd));
      end
    end

    mem_load("lb",   LT_SB,   32'h0000_1003, 32'h80AA_BBCC, 5'd7,  32'hFFFF_FF80);
    mem_load("lbu",  LT_UB,   32'h0000_1001, 32'h80AA_BBCC, 5'd8,  32'h0000_00BB);
    mem_load("lh",   LT_SH,   32'h0000_2002, 32'h8001_1234, 5'd9,  32'hFFFF_8001);
    mem_load("lh0",  LT_SH,   32'h0000_2000, 32'h8001_1234, 5'd10, 32'h0000_1234);
    mem_load("lw",   LT_WORD, 32'h0000_3000, 32'hDEAD_BEEF, 5'd11, 32'hDEAD_BEEF);

    // Halfword store at lane 2, ack withheld one cycle to check field stability.
    clear_in();
    MemWr_in = 1'b1; LoadType_in = LT_SH; LoadByte_in = 2'd2;
    ALUShift_out_in = 32'h0000_2002; StoreData_in = 32'h1234_BEEF; Rd_in = 5'd3;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sh req c%0d", k), 32'(dmem_req), 32'd1);
      chk($sformatf("sh be c%0d", k), 32'(dmem_be), 32'h0000_000C);
      chk($sformatf("sh wdata c%0d", k), dmem_wdata, 32'hBEEF_BEEF);
      chk($sformatf("sh we c%0d", k), 32'(dmem_we), 32'd1);
      chk($sformatf("sh addr c%0d", k), dmem_addr, 32'h0000_2000);
      if (k == 1) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    chk("sh wb_regwr", 32'(WB_RegWr), 32'd0);
    chk("sh stall_done", 32'(Stall), 32'd0);
    chk("sh exc_bus", 32'(Exc_Bus), 32'd0);
    clear_in();
    tick();

    // Byte store at lane 1.
    MemWr_in = 1'b1; LoadType_in = LT_SB; LoadByte_in = 2'd1;
    ALUShift_out_in = 32'h0000_4001; StoreData_in = 32'h0000_00A5;
    tick();
    chk("sb be", 32'(dmem_be), 32'h0000_0002);
    chk("sb wdata", dmem_wdata, 32'hA5A5_A5A5);
    dmem_ack = 1'b1;
    tick();
    clear_in();
    tick();

    // Ack withheld: bus error after 4 ACCESS cycles, then back to IDLE.
    MemtoReg_in = 1'b1; RegWr_in = 1'b1; LoadType_in = LT_WORD;
    ALUShift_out_in = 32'h0000_5000; Rd_in = 5'd20;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to req c%0d", k), 32'(dmem_req), 32'd1);
      chk($sformatf("to stall c%0d", k), 32'(Stall), 32'd1);
      chk($sformatf("to exc_bus c%0d", k), 32'(Exc_Bus), 32'd0);
      tick();
    end
    chk("to exc_bus", 32'(Exc_Bus), 32'd1);
    chk("to wb_regwr", 32'(WB_RegWr), 32'd0);
    chk("to stall_done", 32'(Stall), 32'd0);
    chk("to req_done", 32'(dmem_req), 32'd0);
    clear_in();
    tick();
    chk("to exc_bus_clear", 32'(Exc_Bus), 32'd0);
    RegWr_in = 1'b1; ALUShift_out_in = 32'h0000_0777; Rd_in = 5'd21;
    tick();
    chk("to idle_wb_regwr", 32'(WB_RegWr), 32'd1);
    chk("to idle_wb_data", WB_Data, 32'h0000_0777);

    // Overflow cancels a memory op.
    clear_in();
    Overflow_in = 1'b1; RegWr_in = 1'b1; MemWr_in = 1'b1; ALUShift_out_in = 32'h0000_6000;
    #1;
    chk("ovf stall", 32'(Stall), 32'd0);
    tick();
    chk("ovf req", 32'(dmem_req), 32'd0);
    chk("ovf exc_ovf", 32'(Exc_Ovf), 32'd1);
    chk("ovf wb_regwr", 32'(WB_RegWr), 32'd0);
    clear_in();
    tick();
    chk("ovf exc_ovf_clear", 32'(Exc_Ovf), 32'd0);

    // Misaligned halfword load.
    MemtoReg_in = 1'b1; RegWr_in = 1'b1; LoadType_in = LT_SH; LoadByte_in = 2'd1;
    ALUShift_out_in = 32'h0000_7001;
    #1;
    chk("mis stall", 32'(Stall), 32'd0);
    tick();
    chk("mis req", 32'(dmem_req), 32'd0);
    chk("mis exc_bus", 32'(Exc_Bus), 32'd1);
    chk("mis wb_regwr", 32'(WB_RegWr), 32'd0);
    clear_in();
    tick();

    // Reset while a load is in ACCESS; a late ack must not write back.
    RegWr_in = 1'b1; ALUShift_out_in = 32'h0000_0123; Rd_in = 5'd2;
    tick();
    MemtoReg_in = 1'b1; LoadType_in = LT_WORD; ALUShift_out_in = 32'h0000_8000; Rd_in = 5'd9;
    tick();
    chk("rst req_before", 32'(dmem_req), 32'd1);
    clear_in();
    Reset = 1'b0;
    tick();
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst wb_data", WB_Data, 32'd0);
    chk("rst wb_rd", 32'(WB_Rd), 32'd0);
    chk("rst wb_regwr", 32'(WB_RegWr), 32'd0);
    chk("rst exc_bus", 32'(Exc_Bus), 32'd0);
    chk("rst stall", 32'(Stall), 32'd0);
    Reset = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    chk("rst late_ack_wb_regwr", 32'(WB_RegWr), 32'd0);
    chk("rst late_ack_req", 32'(dmem_req), 32'd0);
    chk("rst late_ack_stall", 32'(Stall), 32'd0);
    clear_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
